// File: rtl/regfile_pkg.sv
// Shared types, default sizes and the address-validity helper for the
// scoreboarded register file.
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  typedef logic [$clog2(NREGS_DEFAULT)-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_ADDR = '0;

  // True when the address names a real, writable register.
  function automatic logic addr_valid(input int unsigned addr,
                                      input int unsigned nregs,
                                      input logic        zero_reg);
    return (addr < nregs) && !(zero_reg && (addr == 32'(ZERO_ADDR)));
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: masks invalid addresses, forwards a same-cycle
// writeback and hides the busy flag of a register being forwarded.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREGS    = NREGS_DEFAULT,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] regs [NREGS],
  input  logic [NREGS-1:0] busy,
  input  logic            wr_commit,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_busy
);

  logic valid;
  logic bypass_hit;

  assign valid      = addr_valid(32'(rd_addr), NREGS, ZERO_REG != 0);
  // wr_commit already implies a valid write address, so a match implies a valid read.
  assign bypass_hit = (BYPASS != 0) && wr_commit && (wr_addr == rd_addr);

  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    if (bypass_hit) begin
      rd_data = wr_data;
    end else if (valid) begin
      rd_data = regs[rd_addr];
      rd_busy = busy[rd_addr];
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised multi-read-port register file with write bypass and a
// per-register busy scoreboard for RAW hazard detection.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREGS    = NREGS_DEFAULT,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS),
  localparam int CW      = $clog2(NREGS + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic                wr_en_i,
  input  logic [AW-1:0]       wr_addr_i,
  input  logic [XLEN-1:0]     wr_data_i,
  input  logic                issue_en_i,
  input  logic [AW-1:0]       issue_addr_i,
  input  logic                flush_i,
  output logic [CW-1:0]       busy_cnt_o
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [CW-1:0]    busy_cnt_nxt;
  logic             wr_commit;
  logic             issue_ok;

  assign wr_commit = wr_en_i    && addr_valid(32'(wr_addr_i),    NREGS, ZERO_REG != 0);
  assign issue_ok  = issue_en_i && addr_valid(32'(issue_addr_i), NREGS, ZERO_REG != 0);

  // Priority: flush, then a new issue (newer producer), then writeback.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    busy_nxt     = busy;
    busy_cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (flush_i)
        busy_nxt[i] = 1'b0;
      else if (issue_ok && (issue_addr_i == AW'(i)))
        busy_nxt[i] = 1'b1;
      else if (wr_commit && (wr_addr_i == AW'(i)))
        busy_nxt[i] = 1'b0;
    end
    for (int i = 0; i < NREGS; i++)
      busy_cnt_nxt = busy_cnt_nxt + CW'(busy_nxt[i]);
  end

  // NOTE: the storage is a flop array rather than an SRAM macro, so it can and
  // must be cleared by the asynchronous reset; a RAM-mapped array could not be.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      busy       <= '0;
      busy_cnt_o <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (wr_commit)
        regs[wr_addr_i] <= wr_data_i;
      busy       <= busy_nxt;
      busy_cnt_o <= busy_cnt_nxt;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    rf_read_port #(
      .XLEN    (XLEN),
      .NREGS   (NREGS),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_port (
      .rd_addr  (rd_addr_i[k*AW +: AW]),
      .regs     (regs),
      .busy     (busy),
      .wr_commit(wr_commit),
      .wr_addr  (wr_addr_i),
      .wr_data  (wr_data_i),
      .rd_data  (rd_data_o[k*XLEN +: XLEN]),
      .rd_busy  (rd_busy_o[k])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb; a BYPASS=0 copy shares the stimulus so the
// non-forwarding read behaviour is checked alongside the default build.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int CW   = 6;
  localparam int NRD  = 2;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [NRD*AW-1:0]   rd_addr_i;
  logic                wr_en_i;
  logic [AW-1:0]       wr_addr_i;
  logic [XLEN-1:0]     wr_data_i;
  logic                issue_en_i;
  logic [AW-1:0]       issue_addr_i;
  logic                flush_i;

  logic [NRD*XLEN-1:0] rd_data_o,  nb_rd_data_o;
  logic [NRD-1:0]      rd_busy_o,  nb_rd_busy_o;
  logic [CW-1:0]       busy_cnt_o, nb_busy_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  regfile_sb dut (
    .clk_i, .rst_i, .rd_addr_i, .rd_data_o, .rd_busy_o,
    .wr_en_i, .wr_addr_i, .wr_data_i, .issue_en_i, .issue_addr_i,
    .flush_i, .busy_cnt_o
  );

  regfile_sb #(.BYPASS(0)) dut_nb (
    .clk_i, .rst_i, .rd_addr_i,
    .rd_data_o (nb_rd_data_o),
    .rd_busy_o (nb_rd_busy_o),
    .wr_en_i, .wr_addr_i, .wr_data_i, .issue_en_i, .issue_addr_i,
    .flush_i,
    .busy_cnt_o(nb_busy_cnt_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    wr_en_i    = 1'b0;
    issue_en_i = 1'b0;
    flush_i    = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr_i = {a1, a0};
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en_i   = 1'b1;
    wr_addr_i = a;
    wr_data_i = d;
  endtask

  task automatic do_issue(input logic [AW-1:0] a);
    issue_en_i   = 1'b1;
    issue_addr_i = a;
  endtask

  function automatic logic [XLEN-1:0] rd0(input logic [NRD*XLEN-1:0] v);
    return v[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] rd1(input logic [NRD*XLEN-1:0] v);
    return v[2*XLEN-1:XLEN];
  endfunction

  initial begin
    rst_i        = 1'b1;
    wr_addr_i    = '0;
    wr_data_i    = '0;
    issue_addr_i = '0;
    idle();
    set_rd(5'd0, 5'd0);
    #12 rst_i = 1'b0;
    tick();

    // Reset state
    set_rd(5'd5, 5'd31);
    #1;
    check("reset_rd0",  rd0(rd_data_o), 32'h0);
    check("reset_busy", rd_busy_o, 2'b00);
    check("reset_cnt",  busy_cnt_o, 6'd0);

    // Write then read on both ports
    do_write(5'd7, 32'h1234_5678);
    tick();
    idle();
    set_rd(5'd7, 5'd7);
    #1;
    check("wr_rd_p0", rd0(rd_data_o), 32'h1234_5678);
    check("wr_rd_p1", rd1(rd_data_o), 32'h1234_5678);

    // Register 0 is hardwired: write and issue both ignored
    do_write(5'd0, 32'hFFFF_FFFF);
    do_issue(5'd0);
    set_rd(5'd0, 5'd0);
    #1;
    check("x0_bypass", rd0(rd_data_o), 32'h0);
    tick();
    idle();
    #1;
    check("x0_rd",   rd0(rd_data_o), 32'h0);
    check("x0_busy", rd_busy_o, 2'b00);
    check("x0_cnt",  busy_cnt_o, 6'd0);

    // Bypass: x3 made busy with value 0x11, then written 0x22 while read
    do_write(5'd3, 32'h11);
    do_issue(5'd3);
    tick();
    idle();
    do_write(5'd3, 32'h22);
    set_rd(5'd3, 5'd3);
    #1;
    check("byp_data",    rd0(rd_data_o), 32'h22);
    check("byp_busy",    rd_busy_o, 2'b00);
    check("nobyp_data",  rd0(nb_rd_data_o), 32'h11);
    check("nobyp_busy",  nb_rd_busy_o, 2'b11);
    tick();
    idle();
    #1;
    check("byp_after",   rd1(nb_rd_data_o), 32'h22);
    check("byp_cnt",     busy_cnt_o, 6'd0);

    // Scoreboard: issue, issue+write same reg, write alone
    do_issue(5'd9);
    tick();
    idle();
    set_rd(5'd9, 5'd7);
    #1;
    check("sb_busy",   rd_busy_o, 2'b01);
    check("sb_cnt",    busy_cnt_o, 6'd1);
    do_issue(5'd9);
    do_write(5'd9, 32'hAB);
    tick();
    idle();
    #1;
    check("sb_iw_data", rd0(rd_data_o), 32'hAB);
    check("sb_iw_busy", rd_busy_o, 2'b01);
    check("sb_iw_cnt",  busy_cnt_o, 6'd1);
    do_write(5'd9, 32'hCD);
    #1;
    check("sb_w_byp_busy", rd_busy_o, 2'b00);
    tick();
    idle();
    #1;
    check("sb_w_data", rd0(rd_data_o), 32'hCD);
    check("sb_w_busy", rd_busy_o, 2'b00);
    check("sb_w_cnt",  busy_cnt_o, 6'd0);

    // Flush wins over a same-cycle issue; a same-cycle write still commits
    do_issue(5'd1); tick();
    do_issue(5'd2); tick();
    do_issue(5'd3); tick();
    idle();
    set_rd(5'd1, 5'd3);
    #1;
    check("fl_cnt3",  busy_cnt_o, 6'd3);
    check("fl_busy3", rd_busy_o, 2'b11);
    flush_i = 1'b1;
    do_issue(5'd4);
    do_write(5'd5, 32'h55);
    tick();
    idle();
    set_rd(5'd4, 5'd5);
    #1;
    check("fl_cnt0",  busy_cnt_o, 6'd0);
    check("fl_busy",  rd_busy_o, 2'b00);
    check("fl_wdata", rd1(rd_data_o), 32'h55);
    set_rd(5'd1, 5'd2);
    #1;
    check("fl_busy12", rd_busy_o, 2'b00);

    // Asynchronous reset mid-cycle
    do_write(5'd5, 32'hDEAD_BEEF);
    tick();
    idle();
    do_issue(5'd6);
    tick();
    idle();
    set_rd(5'd5, 5'd6);
    #1;
    check("pre_rst_data", rd0(rd_data_o), 32'hDEAD_BEEF);
    check("pre_rst_busy", rd_busy_o, 2'b10);
    check("pre_rst_cnt",  busy_cnt_o, 6'd1);
    rst_i = 1'b1;
    #1;
    check("rst_data", rd0(rd_data_o), 32'h0);
    check("rst_busy", rd_busy_o, 2'b00);
    check("rst_cnt",  busy_cnt_o, 6'd0);
    tick();
    rst_i = 1'b0;
    tick();
    #1;
    check("post_rst_data", rd0(rd_data_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
